// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator_pkg
//  Purpose  : Shared definitions for the polyphonic voice allocator: note
//             width, note type and the allocator FSM state encodings (also
//             used by the audio register block when it reports status).
//  Revision : 1.0 - initial release
// ============================================================================
package voice_allocator_pkg;

  localparam int NOTE_W = 7;

  typedef logic [NOTE_W-1:0] note_t;

  // Allocator FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Interface : voice_allocator_if
//  Purpose   : Note event valid/ready channel from the CPU register block to
//              the voice allocator.
//  Signals   : ev_valid (event present), ev_ready (allocator can accept),
//              ev_on (1 = note-on, 0 = note-off), ev_note (MIDI note number)
//  Modports  : master = event source, slave = allocator
//  Revision  : 1.0 - initial release
// ============================================================================
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic  ev_valid;
  logic  ev_ready;
  logic  ev_on;
  note_t ev_note;

  modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);

endinterface
`default_nettype wire

// File: rtl/voice_allocator_age_regs.sv
`default_nettype none
// ============================================================================
//  Module   : voice_age_regs
//  Purpose  : NVOICES saturating age counters. On i_bump the selected voice
//             is cleared and every other voice increments (saturating).
//  Ports    : clk, rst (sync, active-high)
//             i_bump  - update strobe
//             i_sel   - index of the voice whose age is cleared
//             o_ages  - packed ages, voice i at [AGEW*i +: AGEW]
//  Revision : 1.0 - initial release
// ============================================================================
module voice_age_regs #(
  parameter int NVOICES = 4,
  parameter int AGEW    = 8,
  parameter int IW      = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    i_bump,
  input  wire logic [IW-1:0]           i_sel,
  output logic      [NVOICES*AGEW-1:0] o_ages
);

  localparam logic [AGEW-1:0] c_age_max = '1;

  for (genvar gi = 0; gi < NVOICES; gi++) begin : g_age
    localparam logic [IW-1:0] c_my_idx = IW'(gi);
    logic [AGEW-1:0] r_age;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_age <= '0;
      end else if (i_bump) begin
        if (i_sel == c_my_idx) begin
          r_age <= '0;
        end else if (r_age != c_age_max) begin
          r_age <= r_age + AGEW'(1);
        end
      end
    end

    assign o_ages[gi*AGEW +: AGEW] = r_age;
  end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Purpose  : Polyphonic voice allocator. Accepts note-on/off events, scans
//             the voices one per cycle, then gates an idle voice, retriggers
//             a voice already on the same note, or steals the oldest voice.
//             Retrigger/steal holds the gate low for GAP_CYCLES first.
//  Ports    : clk, rst (sync, active-high)
//             ev          - event channel (slave modport)
//             all_off     - panic: release all voices, abort pending event
//             voice_note  - note of voice i at [7*i+6:7*i]
//             voice_gate  - gate of voice i
//             steal_pulse - one-cycle pulse when a sounding voice is stolen
//  Revision : 1.0 - initial release
// ============================================================================
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NVOICES    = 4,
  parameter int AGEW       = 8,
  parameter int GAP_CYCLES = 64
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  voice_allocator_if.slave               ev,
  input  wire logic                      all_off,
  output logic [NVOICES*NOTE_W-1:0]      voice_note,
  output logic [NVOICES-1:0]             voice_gate,
  output logic                           steal_pulse
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] c_last_idx = IW'(NVOICES - 1);
  localparam logic [GW-1:0] c_gap_load = GW'(GAP_CYCLES - 1);

  logic [1:0]                  r_state;
  logic                        r_ev_on;
  note_t                       r_ev_note;
  logic [IW-1:0]               r_idx;

  // Scan candidates
  logic                        r_same_vld;
  logic [IW-1:0]               r_same_idx;
  logic                        r_free_vld;
  logic [IW-1:0]               r_free_idx;
  logic [AGEW-1:0]             r_free_age;
  logic                        r_old_vld;
  logic [IW-1:0]               r_old_idx;
  logic [AGEW-1:0]             r_old_age;

  logic [IW-1:0]               r_tgt_idx;
  logic [GW-1:0]               r_gap_cnt;
  logic [NVOICES*NOTE_W-1:0]   r_vnote;
  logic [NVOICES-1:0]          r_vgate;
  logic                        r_steal;

  logic [NVOICES*AGEW-1:0]     w_ages;
  logic [AGEW-1:0]             w_cur_age;
  logic                        w_cur_gate;
  logic                        w_cur_match;
  logic [IW-1:0]               w_tgt_idx;
  logic                        w_tgt_gated;
  logic                        w_tgt_stolen;
  logic                        w_age_bump;

  // all_off blocks acceptance in the same cycle it is asserted
  assign ev.ev_ready = (r_state == ST_IDLE) && !all_off;

  always_comb begin
    w_cur_age   = w_ages[r_idx*AGEW +: AGEW];
    w_cur_gate  = r_vgate[r_idx];
    w_cur_match = (r_vnote[r_idx*NOTE_W +: NOTE_W] == r_ev_note);

    if (r_same_vld) begin
      w_tgt_idx = r_same_idx;
    end else if (r_free_vld) begin
      w_tgt_idx = r_free_idx;
    end else begin
      w_tgt_idx = r_old_idx;
    end

    w_tgt_gated  = r_vgate[w_tgt_idx];
    // Only the oldest-voice path counts as a steal, and only if the note moves
    w_tgt_stolen = !r_same_vld && !r_free_vld &&
                   (r_vnote[w_tgt_idx*NOTE_W +: NOTE_W] != r_ev_note);
    w_age_bump   = (r_state == ST_APPLY) && r_ev_on && !all_off && !rst;
  end

  voice_age_regs #(
    .NVOICES (NVOICES),
    .AGEW    (AGEW),
    .IW      (IW)
  ) u_ages (
    .clk    (clk),
    .rst    (rst),
    .i_bump (w_age_bump),
    .i_sel  (w_tgt_idx),
    .o_ages (w_ages)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ev_on    <= 1'b0;
      r_ev_note  <= '0;
      r_idx      <= '0;
      r_same_vld <= 1'b0;
      r_same_idx <= '0;
      r_free_vld <= 1'b0;
      r_free_idx <= '0;
      r_free_age <= '0;
      r_old_vld  <= 1'b0;
      r_old_idx  <= '0;
      r_old_age  <= '0;
      r_tgt_idx  <= '0;
      r_gap_cnt  <= '0;
      r_vnote    <= '0;
      r_vgate    <= '0;
      r_steal    <= 1'b0;
    end else if (all_off) begin
      // Notes and ages are kept so a later note-on still sees voice history
      r_vgate <= '0;
      r_state <= ST_IDLE;
      r_steal <= 1'b0;
    end else begin
      r_steal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ev.ev_valid) begin
            r_ev_on    <= ev.ev_on;
            r_ev_note  <= ev.ev_note;
            r_idx      <= '0;
            r_same_vld <= 1'b0;
            r_free_vld <= 1'b0;
            r_old_vld  <= 1'b0;
            r_state    <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (r_ev_on) begin
            if (w_cur_gate && w_cur_match && !r_same_vld) begin
              r_same_vld <= 1'b1;
              r_same_idx <= r_idx;
            end
            // Strict '>' keeps the lowest index on an age tie
            if (!w_cur_gate && (!r_free_vld || (w_cur_age > r_free_age))) begin
              r_free_vld <= 1'b1;
              r_free_idx <= r_idx;
              r_free_age <= w_cur_age;
            end
            if (w_cur_gate && (!r_old_vld || (w_cur_age > r_old_age))) begin
              r_old_vld <= 1'b1;
              r_old_idx <= r_idx;
              r_old_age <= w_cur_age;
            end
          end else if (w_cur_gate && w_cur_match) begin
            r_vgate[r_idx] <= 1'b0;
          end

          if (r_idx == c_last_idx) begin
            r_state <= ST_APPLY;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end

        ST_APPLY: begin
          if (r_ev_on) begin
            r_vnote[w_tgt_idx*NOTE_W +: NOTE_W] <= r_ev_note;
            r_tgt_idx <= w_tgt_idx;
            if (w_tgt_gated) begin
              // Drop the gate so the envelope sees a fresh attack after the gap
              r_vgate[w_tgt_idx] <= 1'b0;
              r_gap_cnt          <= c_gap_load;
              r_steal            <= w_tgt_stolen;
              r_state            <= ST_GAP;
            end else begin
              r_vgate[w_tgt_idx] <= 1'b1;
              r_state            <= ST_IDLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_vgate[r_tgt_idx] <= 1'b1;
            r_state            <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign voice_note  = r_vnote;
  assign voice_gate  = r_vgate;
  assign steal_pulse = r_steal;

endmodule
`default_nettype wire
